// File: rtl/dac_sample_scheduler_pkg.sv
// Constants and types shared by the DAC sample scheduler and the DAC driver.
package dac_sample_scheduler_pkg;

    localparam int         DAC_FRAME_LEN = 20;
    localparam logic [7:0] DAC_MIDSCALE  = 8'h80;

    typedef logic [7:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    typedef enum logic {
        LG_CH0 = 1'b0,
        LG_CH1 = 1'b1
    } chan_t;

endpackage

// File: rtl/dac_sample_buf.sv
// One-entry valid/ready holding register for a single DAC sample source.
module dac_sample_buf
    import dac_sample_scheduler_pkg::*;
(
    input  logic       clk_DAC,
    input  logic       rst,
    input  logic       run,
    input  logic       flush,
    input  logic       consume,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       full,
    output logic [7:0] q
);

    sample_t q_r;

    assign ready = run && !full;
    assign q     = q_r;

    // ready is low while full, so accept and consume never collide
    always_ff @(posedge clk_DAC or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            q_r  <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (valid && ready) begin
            full <= 1'b1;
            q_r  <= data;
        end else if (consume) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Shares the serial DAC between two sample sources, loading a new code
// only at frame boundaries so the driver shifts out a stable sample.
module dac_sample_scheduler
    import dac_sample_scheduler_pkg::*;
#(
    parameter int         FRAME_LEN        = DAC_FRAME_LEN,
    parameter logic [7:0] MIDSCALE         = DAC_MIDSCALE,
    parameter bit         ROUND_ROBIN      = 1'b1,
    parameter bit         HOLD_ON_UNDERRUN = 1'b1
) (
    input  logic        clk_DAC,
    input  logic        rst,
    input  logic        enable,
    input  logic        mute,
    input  logic [7:0]  ch0_data,
    input  logic        ch0_valid,
    output logic        ch0_ready,
    input  logic [7:0]  ch1_data,
    input  logic        ch1_valid,
    output logic        ch1_ready,
    output logic [7:0]  DAC_Data,
    output logic        frame_strobe,
    output logic [1:0]  grant,
    output logic [15:0] underrun_cnt
);

    localparam int            CW   = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    logic [CW-1:0] frame_cnt;
    sched_state_t  state;
    chan_t         last_grant;

    logic    load, run, flush;
    logic    full0, full1;
    logic    pick0, pick1;
    sample_t q0, q1;

    assign load  = (frame_cnt == LAST);
    assign run   = (state == RUN);
    assign flush = load && run && !enable;

    // Loser keeps its sample; round robin favours the channel not last served
    assign pick0 = full0 && (!full1 || (ROUND_ROBIN == 1'b0)
                   || (last_grant == LG_CH1));
    assign pick1 = full1 && !pick0;

    assign frame_strobe = load;
    assign grant        = (load && run) ? {pick1, pick0} : 2'b00;

    dac_sample_buf u_buf0 (
        .clk_DAC (clk_DAC),
        .rst     (rst),
        .run     (run),
        .flush   (flush),
        .consume (load && run && pick0),
        .valid   (ch0_valid),
        .data    (ch0_data),
        .ready   (ch0_ready),
        .full    (full0),
        .q       (q0)
    );

    dac_sample_buf u_buf1 (
        .clk_DAC (clk_DAC),
        .rst     (rst),
        .run     (run),
        .flush   (flush),
        .consume (load && run && pick1),
        .valid   (ch1_valid),
        .data    (ch1_data),
        .ready   (ch1_ready),
        .full    (full1),
        .q       (q1)
    );

    always_ff @(posedge clk_DAC or posedge rst) begin
        if (rst) begin
            frame_cnt    <= '0;
            state        <= IDLE;
            last_grant   <= LG_CH1;
            DAC_Data     <= MIDSCALE;
            underrun_cnt <= '0;
        end else begin
            frame_cnt <= load ? '0 : frame_cnt + 1'b1;
            if (load) begin
                state <= enable ? RUN : IDLE;
                if (!run) begin
                    DAC_Data <= MIDSCALE;
                end else if (pick0 || pick1) begin
                    last_grant <= pick1 ? LG_CH1 : LG_CH0;
                    DAC_Data   <= mute ? MIDSCALE : (pick1 ? q1 : q0);
                end else begin
                    if (underrun_cnt != 16'hFFFF)
                        underrun_cnt <= underrun_cnt + 1'b1;
                    if (mute || !HOLD_ON_UNDERRUN)
                        DAC_Data <= MIDSCALE;
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Scoreboard bench: a round-robin/hold instance and a fixed-priority/midscale instance share stimulus.
module tb_dac_sample_scheduler;

    logic       clk_DAC = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       mute = 1'b0;
    logic [7:0] ch0_data = 8'h00;
    logic [7:0] ch1_data = 8'h00;
    logic       ch0_valid = 1'b0;
    logic       ch1_valid = 1'b0;

    logic        r0_a, r1_a, strobe_a;
    logic [7:0]  dac_a;
    logic [1:0]  grant_a;
    logic [15:0] urun_a;
    logic        r0_b, r1_b, strobe_b;
    logic [7:0]  dac_b;
    logic [1:0]  grant_b;
    logic [15:0] urun_b;

    dac_sample_scheduler dut_a (
        .clk_DAC (clk_DAC), .rst (rst), .enable (enable), .mute (mute),
        .ch0_data (ch0_data), .ch0_valid (ch0_valid), .ch0_ready (r0_a),
        .ch1_data (ch1_data), .ch1_valid (ch1_valid), .ch1_ready (r1_a),
        .DAC_Data (dac_a), .frame_strobe (strobe_a), .grant (grant_a),
        .underrun_cnt (urun_a)
    );

    dac_sample_scheduler #(.ROUND_ROBIN (1'b0), .HOLD_ON_UNDERRUN (1'b0)) dut_b (
        .clk_DAC (clk_DAC), .rst (rst), .enable (enable), .mute (mute),
        .ch0_data (ch0_data), .ch0_valid (ch0_valid), .ch0_ready (r0_b),
        .ch1_data (ch1_data), .ch1_valid (ch1_valid), .ch1_ready (r1_b),
        .DAC_Data (dac_b), .frame_strobe (strobe_b), .grant (grant_b),
        .underrun_cnt (urun_b)
    );

    always #5 clk_DAC = ~clk_DAC;

    // Reference model of the driver-aligned frame counter
    int tcnt = 0;
    always @(posedge clk_DAC or posedge rst) begin
        if (rst) tcnt <= 0;
        else     tcnt <= (tcnt == 19) ? 0 : tcnt + 1;
    end

    typedef struct packed {
        logic [7:0]  data;
        logic [1:0]  grant;
        logic [15:0] urun;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [3:0] rdy5;

    task automatic push(input logic [7:0] da, input logic [7:0] db,
                        input logic [1:0] ga, input logic [1:0] gb,
                        input logic [15:0] ua, input logic [15:0] ub);
        qa.push_back('{data: da, grant: ga, urun: ua});
        qb.push_back('{data: db, grant: gb, urun: ub});
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        @(negedge clk_DAC);
        n_vec++;
        if ({dac_a, grant_a, strobe_a, r0_a, r1_a, urun_a} !==
            {8'h80, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            n_err++;
            $display("FAIL %s reset_a got dac=%h g=%b s=%b rdy=%b%b u=%0d want dac=80 g=00 s=0 rdy=00 u=0",
                     tag, dac_a, grant_a, strobe_a, r0_a, r1_a, urun_a);
        end
        n_vec++;
        if ({dac_b, grant_b, strobe_b, r0_b, r1_b, urun_b} !==
            {8'h80, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            n_err++;
            $display("FAIL %s reset_b got dac=%h g=%b s=%b rdy=%b%b u=%0d want dac=80 g=00 s=0 rdy=00 u=0",
                     tag, dac_b, grant_b, strobe_b, r0_b, r1_b, urun_b);
        end
        enable = 1'b0; mute = 1'b0;
        ch0_valid = 1'b0; ch1_valid = 1'b0;
        rst = 1'b0;
    endtask

    // One full frame: drive at count 0, check grant in the load cycle,
    // check the new code at the following count 0.
    task automatic run_frame(input string tag, input logic en, input logic m,
                             input logic v0, input logic [7:0] d0,
                             input logic v1, input logic [7:0] d1);
        int guard = 0;
        logic tbad = 1'b0;
        logic sbad = 1'b0;
        logic [7:0] h_a, h_b;
        exp_t ea, eb;
        while (tcnt != 0 && guard < 40) begin
            @(negedge clk_DAC);
            guard++;
        end
        enable = en; mute = m;
        ch0_valid = v0; ch0_data = d0;
        ch1_valid = v1; ch1_data = d1;
        h_a = dac_a; h_b = dac_b;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk_DAC);
            if (strobe_a !== (c == 19) || strobe_b !== (c == 19)) tbad = 1'b1;
            if (dac_a !== h_a || dac_b !== h_b) sbad = 1'b1;
            if (c == 5) rdy5 = {r0_a, r1_a, r0_b, r1_b};
        end
        if (qa.size() == 0 || qb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s scoreboard got=empty want=entry", tag);
        end else begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            n_vec++;
            if (grant_a !== ea.grant || grant_b !== eb.grant) begin
                n_err++;
                $display("FAIL %s grant got a=%b b=%b want a=%b b=%b",
                         tag, grant_a, grant_b, ea.grant, eb.grant);
            end
            @(negedge clk_DAC);
            n_vec++;
            if (dac_a !== ea.data || dac_b !== eb.data) begin
                n_err++;
                $display("FAIL %s dac got a=%h b=%h want a=%h b=%h",
                         tag, dac_a, dac_b, ea.data, eb.data);
            end
            n_vec++;
            if (urun_a !== ea.urun || urun_b !== eb.urun) begin
                n_err++;
                $display("FAIL %s underrun got a=%0d b=%0d want a=%0d b=%0d",
                         tag, urun_a, urun_b, ea.urun, eb.urun);
            end
        end
        n_vec++;
        if (tbad) begin
            n_err++;
            $display("FAIL %s strobe_timing got=off-count want=only-count19", tag);
        end
        n_vec++;
        if (sbad) begin
            n_err++;
            $display("FAIL %s dac_stable got=changed-midframe want=stable", tag);
        end
    endtask

    task automatic check_rdy(input string tag, input logic [3:0] want);
        n_vec++;
        if (rdy5 !== want) begin
            n_err++;
            $display("FAIL %s ready got=%b want=%b", tag, rdy5, want);
        end
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_idle();
        apply_reset("idle");
        for (int i = 0; i < 3; i++) begin
            push(8'h80, 8'h80, 2'b00, 2'b00, 16'd0, 16'd0);
            run_frame("idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
            check_rdy("idle", 4'b0000);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3] = '{8'h11, 8'h22, 8'h33};
        apply_reset("b2b");
        push(8'h80, 8'h80, 2'b00, 2'b00, 16'd0, 16'd0);
        run_frame("b2b_entry", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            push(seq[i], seq[i], 2'b01, 2'b01, 16'd0, 16'd0);
            run_frame("b2b", 1'b1, 1'b0, 1'b1, seq[i], 1'b0, 8'h00);
            check_rdy("b2b", 4'b0101);
        end
        push(8'h44, 8'h44, 2'b01, 2'b01, 16'd0, 16'd0);
        run_frame("b2b_exit", 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 8'h00);
        push(8'h80, 8'h80, 2'b00, 2'b00, 16'd0, 16'd0);
        run_frame("b2b_idle", 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 8'h66);
        check_rdy("b2b_idle", 4'b0000);
    endtask

    task automatic test_arbitration();
        apply_reset("arb");
        push(8'h80, 8'h80, 2'b00, 2'b00, 16'd0, 16'd0);
        run_frame("arb_entry", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push(8'hA0, 8'hA0, 2'b01, 2'b01, 16'd0, 16'd0);
            else            push(8'hB0, 8'hA0, 2'b10, 2'b01, 16'd0, 16'd0);
            run_frame("arb", 1'b1, 1'b0, 1'b1, 8'hA0, 1'b1, 8'hB0);
            check_rdy("arb", 4'b0000);
        end
    endtask

    task automatic test_underrun();
        apply_reset("urun");
        push(8'h80, 8'h80, 2'b00, 2'b00, 16'd0, 16'd0);
        run_frame("urun_entry", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        push(8'h5C, 8'h5C, 2'b01, 2'b01, 16'd0, 16'd0);
        run_frame("urun_load", 1'b1, 1'b0, 1'b1, 8'h5C, 1'b0, 8'h00);
        for (int k = 1; k <= 4; k++) begin
            push(8'h5C, 8'h80, 2'b00, 2'b00, 16'(k), 16'(k));
            run_frame("urun", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        end
    endtask

    task automatic test_mute_and_reset();
        int k = 0;
        apply_reset("mute");
        push(8'h80, 8'h80, 2'b00, 2'b00, 16'd0, 16'd0);
        run_frame("mute_entry", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        push(8'h80, 8'h80, 2'b01, 2'b01, 16'd0, 16'd0);
        run_frame("mute", 1'b1, 1'b1, 1'b1, 8'hF0, 1'b0, 8'h00);
        push(8'h3C, 8'h3C, 2'b01, 2'b01, 16'd0, 16'd0);
        run_frame("unmute", 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
        push(8'h3C, 8'h80, 2'b00, 2'b00, 16'd1, 16'd1);
        run_frame("mute_urun", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        while (tcnt != 7 && k < 40) begin
            @(negedge clk_DAC);
            k++;
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (dac_a !== 8'h80 || urun_a !== 16'd0 || urun_b !== 16'd0) begin
            n_err++;
            $display("FAIL midreset got dac=%h ua=%0d ub=%0d want dac=80 ua=0 ub=0",
                     dac_a, urun_a, urun_b);
        end
        @(negedge clk_DAC);
        rst = 1'b0;
        enable = 1'b0;
        k = 0;
        while (!strobe_a && k < 30) begin
            @(negedge clk_DAC);
            k++;
        end
        n_vec++;
        if (k != 19) begin
            n_err++;
            $display("FAIL midreset_count got=%0d want=19 cycles to strobe", k);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_back_to_back();
        test_arbitration();
        test_underrun();
        test_mute_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dac_sample_scheduler.md
Name: dac_sample_scheduler

Overview:
- Feeds the 8-bit parallel sample input of the serial DAC driver and shares that DAC between two sample sources.
  - Channel 0: low-pass filter output.
  - Channel 1: auxiliary/test source.
- Keeps a 20-cycle frame counter that tracks the driver's free-running frame, and updates the sample only at frame boundaries. The sample is therefore stable while the driver shifts out its bits.
- Sits between the filter/test datapaths and the DAC driver, all on clk_DAC.

Parameters:
- FRAME_LEN, 20, clk_DAC cycles per DAC frame; must equal the driver frame length.
- MIDSCALE, 8'h80, code output when idle, muted, or on underrun with hold disabled.
- ROUND_ROBIN, 1, 1 = alternate priority between channels; 0 = channel 0 fixed priority.
- HOLD_ON_UNDERRUN, 1, 1 = repeat last code on underrun; 0 = output MIDSCALE.

Ports:
- clk_DAC  in  1  DAC bit clock; the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request; sampled only at frame boundary.
- mute  in  1  force MIDSCALE at the next load; samples still consumed.
- ch0_data  in  8  channel 0 sample.
- ch0_valid  in  1  channel 0 sample valid.
- ch0_ready  out  1  channel 0 buffer can accept.
- ch1_data  in  8  channel 1 sample.
- ch1_valid  in  1  channel 1 sample valid.
- ch1_ready  out  1  channel 1 buffer can accept.
- DAC_Data  out  8  parallel sample to DAC driver, registered.
- frame_strobe  out  1  one-cycle pulse in the load cycle (frame_cnt == FRAME_LEN-1).
- grant  out  2  one-hot, pulsed with frame_strobe: channel whose sample was loaded; 2'b00 if none.
- underrun_cnt  out  16  saturating count of frames loaded with no sample available while running.

Behaviour:
- Reset values (asynchronous): frame_cnt=0, state=IDLE, DAC_Data=MIDSCALE, both buffers empty, ch0_ready=ch1_ready=0, frame_strobe=0, grant=0, underrun_cnt=0, last_grant=ch1 (channel 0 wins first).
- Frame counter:
  - Runs 0..FRAME_LEN-1 and wraps, always, in every state.
  - After reset it is 0, aligned with the driver's power-up count of 0.
  - The load cycle is frame_cnt == FRAME_LEN-1. DAC_Data changes only on the clock edge ending the load cycle, so the new code is visible from count 0.
- States:
  - IDLE → RUN at a load cycle with enable=1.
  - RUN → IDLE at a load cycle with enable=0.
  - enable is ignored between load cycles.
- IDLE behaviour:
  - chN_ready=0.
  - Both buffers flushed at the IDLE entry edge.
  - Each load writes MIDSCALE with grant=0.
  - underrun_cnt is not incremented.
- RUN buffers:
  - Each channel has a one-entry buffer; chN_ready = !bufN_full.
  - Accept when chN_valid && chN_ready; the buffer is full on the next cycle.
  - Because ready is low whenever a buffer is full, no accept can coincide with consumption of the same buffer.
  - An accept in the load cycle itself fills the buffer but is not eligible until the next frame; there is no bypass.
- RUN load-cycle selection:
  - Only full buffers are eligible.
  - ROUND_ROBIN=1: the channel other than last_grant has priority when both are full.
  - ROUND_ROBIN=0: channel 0 always has priority.
  - The winner's buffer is cleared, grant is set to its one-hot code, and last_grant is updated. The loser's buffer is kept.
- DAC_Data on load: MIDSCALE if mute=1, otherwise the winner's data. A sample is still consumed and granted when muted.
- Underrun (RUN, no buffer full at load):
  - grant=0; DAC_Data holds if HOLD_ON_UNDERRUN=1, otherwise MIDSCALE.
  - underrun_cnt increments, saturating at 16'hFFFF.
  - Underrun is counted regardless of mute.
- Reset mid-frame: all state returns to reset values immediately. The driver's counter does not reset, so re-alignment is the integrator's responsibility: reset must be applied only at system reset.

Decomposition:
- Shared package: DAC_FRAME_LEN=20 and DAC_MIDSCALE=8'h80, shared with the DAC driver.
- One natural sub-module: dac_sample_buf, the one-entry valid/ready holding register, instantiated per channel.
- Arbitration, frame counter and state machine stay in the top module.

Test Plan:
- Reset, then idle for 3 frames with enable=0 → DAC_Data=8'h80; frame_strobe pulses every 20 cycles at count 19; readies=0; grant=0.
- enable=1; ch0 pushes 8'h11, 8'h22, 8'h33 one per frame; ch1 idle → DAC_Data 8'h11, 8'h22, 8'h33 on successive frames, each changing only at the count 19→0 edge; grant=2'b01 each frame; underrun_cnt=0.
- ROUND_ROBIN=1 with both channels kept full (ch0=8'hA0, ch1=8'hB0) → loads alternate A0, B0, A0, B0 starting with A0; grant alternates 01/10; the non-granted ready stays 0.
- ROUND_ROBIN=0, same stimulus → ch0 wins every frame; ch1_ready stays 0 and the ch1 sample is never loaded.
- With HOLD_ON_UNDERRUN=1 after loading 8'h5C, stop all valids for 4 frames → DAC_Data stays 8'h5C and underrun_cnt=4. With HOLD_ON_UNDERRUN=0 → 8'h80.
- mute=1 with ch0 supplying 8'hF0 → DAC_Data=8'h80 and grant=01 (sample consumed). Assert rst mid-frame (count 7) → DAC_Data=8'h80, counter=0, underrun_cnt=0 immediately.
